// File: rtl/des_round_engine.sv
// Iterative DES round engine: IP, sixteen Feistel rounds fed by external subkeys, swap and FP.
// ROUNDS_PER_CYCLE rounds are unrolled per clock; valid/ready handshakes on input and output.
module des_round_engine #(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        decrypt,
    input  logic [63:0] data_in,
    input  logic [47:0] sub_key1,
    input  logic [47:0] sub_key2,
    input  logic [47:0] sub_key3,
    input  logic [47:0] sub_key4,
    input  logic [47:0] sub_key5,
    input  logic [47:0] sub_key6,
    input  logic [47:0] sub_key7,
    input  logic [47:0] sub_key8,
    input  logic [47:0] sub_key9,
    input  logic [47:0] sub_key10,
    input  logic [47:0] sub_key11,
    input  logic [47:0] sub_key12,
    input  logic [47:0] sub_key13,
    input  logic [47:0] sub_key14,
    input  logic [47:0] sub_key15,
    input  logic [47:0] sub_key16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out,
    output logic        busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int unsigned RPC = ROUNDS_PER_CYCLE;
    localparam logic [4:0] RPC_STEP = 5'(RPC);

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8 || RPC == 16)) begin : g_bad_rpc
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int unsigned IP_TAB [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int unsigned FP_TAB [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
    localparam int unsigned E_TAB [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int unsigned P_TAB [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    // Each box is indexed by {row, col} = {b1, b6, b2..b5} of its 6-bit input.
    localparam int unsigned SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic        mode_q, mode_d;
    logic [63:0] data_out_q, data_out_d;

    logic [47:0] keys [16];
    assign keys = '{sub_key1, sub_key2, sub_key3, sub_key4, sub_key5, sub_key6, sub_key7,
                    sub_key8, sub_key9, sub_key10, sub_key11, sub_key12, sub_key13, sub_key14,
                    sub_key15, sub_key16};

    logic [63:0] ip_out, fp_in, fp_out;
    for (genvar i = 0; i < 64; i++) begin : g_perm
        assign ip_out[63-i] = data_in[64-IP_TAB[i]];
        assign fp_out[63-i] = fp_in[64-FP_TAB[i]];
    end

    logic [RPC:0][31:0] lc, rc;
    assign lc[0] = l_q;
    assign rc[0] = r_q;

    for (genvar g = 0; g < RPC; g++) begin : g_round
        logic [3:0]  n;
        logic [3:0]  kidx;
        logic [47:0] ex;
        logic [31:0] sb, pf;
        assign n    = cnt_q[3:0] + 4'(g);
        assign kidx = mode_q ? 4'd15 - n : n;
        for (genvar i = 0; i < 48; i++) begin : g_e
            assign ex[47-i] = rc[g][32-E_TAB[i]] ^ keys[kidx][47-i];
        end
        for (genvar b = 0; b < 8; b++) begin : g_s
            assign sb[31-4*b -: 4] =
                SBOX[b][{ex[47-6*b], ex[42-6*b], ex[46-6*b -: 4]}][3:0];
        end
        for (genvar i = 0; i < 32; i++) begin : g_p
            assign pf[31-i] = sb[32-P_TAB[i]];
        end
        assign lc[g+1] = rc[g];
        assign rc[g+1] = lc[g] ^ pf;
    end

    // Halves are swapped on the way into FP.
    assign fp_in = {rc[RPC], lc[RPC]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        l_d        = l_q;
        r_d        = r_q;
        mode_d     = mode_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    {l_d, r_d} = ip_out;
                    mode_d     = decrypt;
                    cnt_d      = '0;
                    state_d    = ROUND;
                end
            end
            ROUND: begin
                l_d   = lc[RPC];
                r_d   = rc[RPC];
                cnt_d = cnt_q + RPC_STEP;
                if (cnt_d == 5'd16) begin
                    data_out_d = fp_out;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            l_q        <= '0;
            r_q        <= '0;
            mode_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            l_q        <= l_d;
            r_q        <= r_d;
            mode_q     <= mode_d;
            data_out_q <= data_out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign data_out  = data_out_q;
endmodule

// File: doc/des_round_engine.md
Name: des_round_engine

Overview:
- Iterative DES datapath directly downstream of the subkey generator.
- Consumes its sixteen 48-bit subkeys and encrypts or decrypts one 64-bit block per transaction.
- Datapath: initial permutation (IP), 16 Feistel rounds (E-expansion, subkey XOR, S1–S8, P), swap, final permutation (FP).
- Valid/ready handshakes on both sides; sits between the block-input buffer and the output formatter.

Parameters:
- ROUNDS_PER_CYCLE, default 1: Feistel rounds evaluated per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  data_in, decrypt and subkeys are presented.
- in_ready  output  1  engine can accept a block.
- decrypt  input  1  0 = encrypt, 1 = decrypt; sampled at accept.
- data_in  input  64  plaintext or ciphertext; bit 63 = DES bit 1.
- sub_key1..sub_key16  input  48 each  round subkeys K1..K16; bit 47 = subkey bit 1.
- out_valid  output  1  data_out holds a result.
- out_ready  input  1  downstream accepts the result.
- data_out  output  64  result; bit 63 = DES bit 1.
- busy  output  1  high while in ROUND or DONE.

Behaviour:
- One clock. Reset is synchronous and active-high: clk and rst as named above.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, busy = 0, data_out = 0, round counter = 0, L = 0, R = 0, mode = 0.
- The FSM has three states: IDLE, ROUND and DONE.
- IDLE:
  - in_ready = 1.
  - Accept occurs when in_valid && in_ready.
  - On accept: {L,R} <= IP(data_in); mode <= decrypt; cnt <= 0; go to ROUND.
- ROUND:
  - Each cycle applies ROUND_PER_CYCLE consecutive rounds, n = cnt .. cnt+RPC-1.
  - Each round computes L' = R and R' = L ^ P(S(E(R) ^ Kn)).
  - Subkey index: encrypt uses K(n+1); decrypt uses K(16-n).
  - cnt increments by RPC each cycle.
  - When the last round completes: data_out <= FP({R16,L16}) (swap applied before FP); out_valid <= 1; go to DONE.
- DONE:
  - out_valid = 1 and data_out is held stable until out_valid && out_ready.
  - On that handshake: out_valid <= 0; go to IDLE.
  - data_out keeps its last value after the handshake.
- Latency: accept edge to out_valid high is 16/RPC + 1 cycles, i.e. 17 at the default.
- Throughput: one block per 16/RPC + 2 cycles when out_ready is held high.
- in_ready is 0 in ROUND and DONE. There is no overlap: a new accept can occur no earlier than the cycle after the output handshake.
- Subkeys are not latched. sub_key1..16 must stay stable from the accept cycle through the last ROUND cycle. Changes after the block enters DONE do not affect data_out.
- decrypt and data_in are sampled only at accept. Changes while busy are ignored.
- in_valid asserted while busy: no effect; the block is not queued.
- out_ready asserted while out_valid = 0: ignored.
- rst asserted in any state (including mid-ROUND or DONE with out_valid high):
  - The next edge forces all reset values.
  - The in-flight block is discarded and no out_valid pulse is produced.
- S-boxes, E, P, IP and FP are the FIPS 46-3 tables, implemented as combinational constant logic.
- No file-loaded tables and no initial blocks. The block must synthesize with no memory-init files.
- Permutation bit numbering: DES bit i maps to vector bit 64-i (blocks), 48-i (subkeys), 32-i (halves).

Test Plan:
- Encrypt, standard vector:
  - Stimulus: key 133457799BBCDFF1 via the subkey generator (K1 must read 1B02EFFC7072); data_in 0123456789ABCDEF; decrypt = 0; accept at cycle 0.
  - Response: out_valid rises at cycle 17; data_out = 85E813540F0AB405.
- Decrypt round trip:
  - Stimulus: same key; data_in 85E813540F0AB405; decrypt = 1.
  - Response: data_out = 0123456789ABCDEF.
- All-zero vector:
  - Stimulus: key 0000000000000000, data_in 0000000000000000, encrypt.
  - Response: data_out = 8CA64DE9C1B123A7.
- Backpressure:
  - Stimulus: out_ready held 0 for 10 cycles after out_valid; in_valid held high throughout.
  - Response: data_out stable; in_ready = 0 throughout; exactly one accept after the handshake.
- Reset mid-operation:
  - Stimulus: rst = 1 at round 8; then release and send a new block.
  - Response: the next cycle shows in_ready = 1, out_valid = 0, data_out = 0; no stale result appears; the new block completes with the correct value.
- Parameter sweep:
  - Stimulus: ROUNDS_PER_CYCLE = 4 and 16; rerun the first three scenarios.
  - Response: identical results; latency 5 and 2 cycles respectively.
